// File: rtl/vga_frame_scheduler_if.sv
// Purpose : connection bundle between the requester (CPU-side writer plus the
//           video sync source) and vga_frame_scheduler.
// Signals : vs         - active-low vertical sync
//           wr_en      - shadow write strobe
//           wr_addr    - shadow word index
//           wr_data    - shadow write data
//           wr_err     - one-cycle pulse, out-of-range write dropped
//           commit_req - level request to commit shadow to active
//           commit_ack - one-cycle pulse, commit done
//           pending    - commit armed, waiting for the next frame
//           act_bus    - active words, word i at [W*i +: W]
//           mode_chg   - one-cycle pulse with commit_ack on a mode-field change
//           frame_cnt  - count of vs falling edges
// Modports: master = requester side, slave = scheduler side.
interface vga_frame_scheduler_if #(
  parameter int unsigned NREG = 11,
  parameter int unsigned W    = 32
);
  localparam int unsigned AW  = 4;
  localparam int unsigned FCW = 16;

  logic                vs;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [W-1:0]        wr_data;
  logic                wr_err;
  logic                commit_req;
  logic                commit_ack;
  logic                pending;
  logic [NREG*W-1:0]   act_bus;
  logic                mode_chg;
  logic [FCW-1:0]      frame_cnt;

  modport master (
    output vs, wr_en, wr_addr, wr_data, commit_req,
    input  wr_err, commit_ack, pending, act_bus, mode_chg, frame_cnt
  );

  modport slave (
    input  vs, wr_en, wr_addr, wr_data, commit_req,
    output wr_err, commit_ack, pending, act_bus, mode_chg, frame_cnt
  );
endinterface

// File: rtl/vga_frame_scheduler.sv
// Purpose : holds the game-state words seen by the VGA pixel processors.
//           CPU writes land in a shadow file; a four-phase commit handshake
//           copies the whole shadow file into the active file on the next
//           vertical-sync falling edge, so a frame never shows a torn update.
//           Also counts frames and flags screen-mode changes.
// Ports   : vga_clk - pixel clock, the only clock
//           reset   - synchronous, active-high reset
//           bus     - vga_frame_scheduler_if.slave (writes, commit handshake,
//                     active word bus, frame counter, mode-change pulse)
// All logic runs in the vga_clk domain; the requester synchronises its inputs.
module vga_frame_scheduler #(
  parameter int unsigned NREG     = 11,
  parameter int unsigned W        = 32,
  parameter int unsigned MODE_IDX = 10
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  vga_frame_scheduler_if.slave bus
);

  localparam int unsigned FCW = 16;
  localparam int unsigned MW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  state_t          state_q;
  logic [W-1:0]    shadow_q [NREG];
  logic [W-1:0]    active_q [NREG];
  logic            vs_prev_q;
  logic            wr_err_q;
  logic            commit_ack_q;
  logic            mode_chg_q;
  logic            pending_q;
  logic [FCW-1:0]  frame_cnt_q;

  logic            vs_fall;
  logic            wr_in_range;
  logic            mode_differs;

  // vs is active low: a frame starts when it goes 1 -> 0.
  assign vs_fall      = vs_prev_q & ~bus.vs;
  assign wr_in_range  = 32'(bus.wr_addr) < NREG;
  assign mode_differs = shadow_q[MODE_IDX][W-1 -: MW] != active_q[MODE_IDX][W-1 -: MW];

  // Sync edge detect, frame counter, shadow writes and commit handshake.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      vs_prev_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      commit_ack_q <= 1'b0;
      mode_chg_q   <= 1'b0;
      pending_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vs_prev_q    <= bus.vs;
      wr_err_q     <= bus.wr_en & ~wr_in_range;
      commit_ack_q <= 1'b0;
      mode_chg_q   <= 1'b0;

      if (vs_fall) begin
        frame_cnt_q <= frame_cnt_q + FCW'(1);
      end

      // Writes are accepted in every state; a write on the copying edge
      // lands in shadow only, the copy below sees the pre-edge shadow.
      for (int unsigned i = 0; i < NREG; i++) begin
        if (bus.wr_en && (bus.wr_addr == 4'(i))) begin
          shadow_q[i] <= bus.wr_data;
        end
      end

      case (state_q)
        ST_IDLE: begin
          // A vs_fall in the request cycle is ignored; wait for the next frame.
          if (bus.commit_req) begin
            state_q   <= ST_ARMED;
            pending_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!bus.commit_req) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
          end else if (vs_fall) begin
            active_q     <= shadow_q;
            commit_ack_q <= 1'b1;
            mode_chg_q   <= mode_differs;
            pending_q    <= 1'b0;
            state_q      <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state_q <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          // Four-phase: the request must drop before another commit can arm.
          if (!bus.commit_req) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  // Active file only changes on a commit, so it is safe to drive downstream directly.
  for (genvar g = 0; g < NREG; g++) begin : g_act
    assign bus.act_bus[W*g +: W] = active_q[g];
  end

  assign bus.wr_err     = wr_err_q;
  assign bus.commit_ack = commit_ack_q;
  assign bus.mode_chg   = mode_chg_q;
  assign bus.pending    = pending_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler: shadow writes, commit handshake,
// write/commit collision, withdrawn requests, mode-change pulse, frame
// counter wrap and reset while armed.
module tb_vga_frame_scheduler;

  localparam int unsigned NREG = 11;
  localparam int unsigned W    = 32;

  logic vga_clk = 1'b0;
  logic reset;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [W-1:0] exp_act [NREG];
  logic [15:0]  exp_frame;

  vga_frame_scheduler_if #(.NREG(NREG), .W(W)) bus_if ();

  vga_frame_scheduler #(
    .NREG     (NREG),
    .W        (W),
    .MODE_IDX (10)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus_if)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_words(input string tag);
    for (int i = 0; i < int'(NREG); i++) begin
      chk($sformatf("%s_word%0d", tag, i), bus_if.act_bus[W*i +: W], exp_act[i]);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [W-1:0] data);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = addr;
    bus_if.wr_data = data;
    step();
    bus_if.wr_en   = 1'b0;
  endtask

  // One vs high->low->high pulse; checks frame_cnt right after the falling edge.
  task automatic vs_pulse(input string tag);
    bus_if.vs = 1'b0;
    step();
    exp_frame = exp_frame + 16'd1;
    chk({tag, "_frame"}, 32'(bus_if.frame_cnt), 32'(exp_frame));
    bus_if.vs = 1'b1;
    step();
  endtask

  // Full handshake from IDLE with vs idle-high; ack/mode_chg checked in the commit cycle.
  task automatic do_commit(input string tag, input logic exp_mode_chg);
    bus_if.commit_req = 1'b1;
    step();
    chk({tag, "_pending"}, 32'(bus_if.pending), 32'd1);
    bus_if.vs = 1'b0;
    step();
    exp_frame = exp_frame + 16'd1;
    chk({tag, "_ack"}, 32'(bus_if.commit_ack), 32'd1);
    chk({tag, "_mode_chg"}, 32'(bus_if.mode_chg), 32'(exp_mode_chg));
    chk({tag, "_frame"}, 32'(bus_if.frame_cnt), 32'(exp_frame));
    chk_words(tag);
    bus_if.vs         = 1'b1;
    bus_if.commit_req = 1'b0;
    step();
    chk({tag, "_ack_gone"}, 32'(bus_if.commit_ack), 32'd0);
    step();
  endtask

  initial begin
    for (int i = 0; i < int'(NREG); i++) exp_act[i] = '0;
    exp_frame         = 16'd0;
    reset             = 1'b1;
    bus_if.vs         = 1'b1;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_addr    = 4'd0;
    bus_if.wr_data    = '0;
    bus_if.commit_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state.
    chk_words("rst");
    chk("rst_pending", 32'(bus_if.pending), 32'd0);
    chk("rst_ack", 32'(bus_if.commit_ack), 32'd0);
    chk("rst_mode_chg", 32'(bus_if.mode_chg), 32'd0);
    chk("rst_wr_err", 32'(bus_if.wr_err), 32'd0);
    chk("rst_frame", 32'(bus_if.frame_cnt), 32'd0);

    // Basic commit of word0; request held past the ack gives no second ack.
    wr(4'd0, 32'h5);
    chk("w0_wr_err", 32'(bus_if.wr_err), 32'd0);
    chk("w0_not_yet_active", bus_if.act_bus[31:0], 32'h0);
    bus_if.commit_req = 1'b1;
    step();
    chk("c1_pending", 32'(bus_if.pending), 32'd1);
    bus_if.vs = 1'b0;
    step();
    exp_frame = 16'd1;
    exp_act[0] = 32'h5;
    chk_words("c1");
    chk("c1_ack", 32'(bus_if.commit_ack), 32'd1);
    chk("c1_pending_low", 32'(bus_if.pending), 32'd0);
    chk("c1_frame", 32'(bus_if.frame_cnt), 32'd1);
    bus_if.vs = 1'b1;
    step();
    chk("c1_ack_one_cycle", 32'(bus_if.commit_ack), 32'd0);
    step();
    bus_if.vs = 1'b0;
    step();
    exp_frame = 16'd2;
    chk("hold_no_ack", 32'(bus_if.commit_ack), 32'd0);
    chk("hold_frame", 32'(bus_if.frame_cnt), 32'd2);
    bus_if.vs = 1'b1;
    step();
    chk("hold_no_ack2", 32'(bus_if.commit_ack), 32'd0);
    chk("hold_not_pending", 32'(bus_if.pending), 32'd0);
    bus_if.commit_req = 1'b0;
    step();

    // Mode change 0 -> 1, then the same mode again.
    wr(4'd10, 32'h2000_0000);
    exp_act[10] = 32'h2000_0000;
    do_commit("mode01", 1'b1);
    do_commit("mode11", 1'b0);

    // Out-of-range write is dropped and flagged for one cycle.
    wr(4'd12, 32'hFFFF_FFFF);
    chk("oor_wr_err", 32'(bus_if.wr_err), 32'd1);
    step();
    chk("oor_wr_err_gone", 32'(bus_if.wr_err), 32'd0);
    do_commit("oor", 1'b0);

    // Withdrawn request: no commit, no ack, active unchanged.
    wr(4'd1, 32'hAB);
    bus_if.commit_req = 1'b1;
    step();
    chk("wd_pending", 32'(bus_if.pending), 32'd1);
    step();
    bus_if.commit_req = 1'b0;
    step();
    chk("wd_pending_low", 32'(bus_if.pending), 32'd0);
    chk("wd_no_ack", 32'(bus_if.commit_ack), 32'd0);
    vs_pulse("wd_vs");
    chk("wd_no_ack_vs", 32'(bus_if.commit_ack), 32'd0);
    chk_words("wd");

    // Write/commit collision: the copy takes the old word8.
    wr(4'd8, 32'h11);
    exp_act[1] = 32'hAB;
    exp_act[8] = 32'h11;
    do_commit("pre_col", 1'b0);
    bus_if.commit_req = 1'b1;
    step();
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = 4'd8;
    bus_if.wr_data = 32'h77;
    bus_if.vs      = 1'b0;
    step();
    exp_frame = exp_frame + 16'd1;
    bus_if.wr_en = 1'b0;
    chk("col_ack", 32'(bus_if.commit_ack), 32'd1);
    chk("col_word8_old", bus_if.act_bus[W*8 +: W], 32'h11);
    bus_if.vs         = 1'b1;
    bus_if.commit_req = 1'b0;
    step();
    step();
    exp_act[8] = 32'h77;
    do_commit("post_col", 1'b0);

    // Frame counter wrap: jump near the top, then two frames.
    force dut.frame_cnt_q = 16'hFFFE;
    step();
    release dut.frame_cnt_q;
    #1;
    exp_frame = 16'hFFFE;
    chk("wrap_preset", 32'(bus_if.frame_cnt), 32'hFFFE);
    vs_pulse("wrap_ffff");
    vs_pulse("wrap_0000");
    chk("wrap_zero", 32'(bus_if.frame_cnt), 32'h0);

    // Reset while armed: pending dropped, active cleared, no ack.
    wr(4'd2, 32'h99);
    bus_if.commit_req = 1'b1;
    step();
    chk("rarm_pending", 32'(bus_if.pending), 32'd1);
    reset     = 1'b1;
    bus_if.vs = 1'b0;
    step();
    reset             = 1'b0;
    bus_if.commit_req = 1'b0;
    for (int i = 0; i < int'(NREG); i++) exp_act[i] = '0;
    exp_frame = 16'd0;
    chk("rarm_pending_low", 32'(bus_if.pending), 32'd0);
    chk("rarm_no_ack", 32'(bus_if.commit_ack), 32'd0);
    chk_words("rarm");
    step();
    // vs held low across reset release is not a frame edge.
    chk("rarm_no_edge", 32'(bus_if.frame_cnt), 32'd0);
    chk("rarm_no_ack2", 32'(bus_if.commit_ack), 32'd0);
    bus_if.vs = 1'b1;
    step();

    // Last write wins; shadow was cleared by reset (word2 write gone).
    wr(4'd3, 32'h1);
    wr(4'd3, 32'h2);
    exp_act[3] = 32'h2;
    do_commit("lastwin", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
